logicalunit_identifier: RTL and testbench
=========================================

Name: logicalunit_identifier

Overview:
Observes (a, b, out) samples from a two-input logical unit and reconstructs that unit's 4-bit func truth table. It is the inverse of the func-programmed logical unit: func[{a,b}] drives out there, and this block recovers func from out. It flags inconsistent observations and idle timeouts, and classifies the recovered function into a named operation. It sits beside the logical unit as a self-check and characterisation monitor.

Parameters:
TIMEOUT_CYCLES, 255, consecutive LEARN cycles without an accepted sample before abort; must be at least 1
CNT_W, 8, width of the sample counter and the idle counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; clears learned state and enters LEARN
sample_valid  input  1  a, b, out_obs carry a valid observation
a  input  1  observed operand a
b  input  1  observed operand b
out_obs  input  1  observed logical-unit output
sample_ready  output  1  high only in LEARN
func_est  output  4  recovered truth table; bit index = {a,b}
seen  output  4  per-entry learned flags
busy  output  1  high in LEARN
done  output  1  high in DONE
conflict  output  1  high in ERROR when caused by contradiction
timeout  output  1  high in ERROR when caused by idle timeout
op_code  output  3  classification, valid while done=1, else 0
sample_cnt  output  CNT_W  accepted samples since start; saturates at all-ones

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all outputs 0, state IDLE, internal idle counter 0.
- States: IDLE, LEARN, DONE, ERROR. All outputs are registered.
- start is honoured in every state. Next cycle: state LEARN; func_est, seen, sample_cnt, idle counter, conflict, timeout and op_code all cleared.
  - If start and an accept occur in the same cycle, start wins and the sample is discarded.
- Accept = sample_valid && sample_ready. Index idx = {a,b}, giving 0..3.
- On accept in LEARN, at the same edge:
  - sample_cnt increments (saturating) and the idle counter clears.
  - If seen[idx]=0: func_est[idx] <= out_obs and seen[idx] <= 1.
  - If seen[idx]=1 and func_est[idx]==out_obs: no table change.
  - If seen[idx]=1 and func_est[idx]!=out_obs: go to ERROR with conflict=1. func_est and seen are frozen at their pre-sample values.
- LEARN to DONE: evaluated on the updated seen value. When seen becomes 4'b1111 at the accept edge, the state is DONE at that same edge. done=1 and op_code become visible in the cycle after the accept that completes the table (latency 1).
- Idle timeout: in LEARN, each cycle without an accept increments the idle counter. When it reaches TIMEOUT_CYCLES, go to ERROR with timeout=1. Partial func_est and seen are retained.
- DONE and ERROR are sticky until start or reset. sample_ready=0 there, and samples are ignored.
- op_code mapping, registered on entry to DONE:
  - 1: AND (func 4'b1000)
  - 2: OR (4'b1110)
  - 3: XOR (4'b0110)
  - 4: NAND (4'b0111)
  - 5: NOR (4'b0001)
  - 6: XNOR (4'b1001)
  - 7: any other table, including constants
  - 0: not DONE
- Reset mid-LEARN: immediate asynchronous clear to IDLE; no partial results retained.
- Exactly one of busy, done, conflict, timeout is high outside IDLE; all four are low in IDLE.

Decomposition:
- Shared package lu_pkg:
  - state enum (IDLE/LEARN/DONE/ERROR)
  - op_code constants OP_NONE..OP_OTHER
  - func constants FUNC_AND=4'b1000, FUNC_OR=4'b1110, FUNC_XOR=4'b0110, FUNC_NAND=4'b0111, FUNC_NOR=4'b0001, FUNC_XNOR=4'b1001
- One natural sub-module: lu_func_classify, a combinational map from func[3:0] to op_code[2:0]. It can be reused by the logical-unit testbench.

Test Plan:
- Reset, then start, then samples (a,b,out) = (0,0,0), (0,1,1), (1,0,1), (1,1,1) on consecutive cycles -> func_est=4'b1110, seen=4'b1111, done=1 one cycle after 4th accept, op_code=2, sample_cnt=4.
- start, then (1,1,1), (1,1,1), (0,0,0), (0,1,0), (1,0,0) -> repeat tolerated, func_est=4'b1000, op_code=1, sample_cnt=5.
- start, then (0,1,1) followed by (0,1,0) -> conflict=1, func_est=4'b0010, seen=4'b0010, sample_ready=0, done stays 0.
- TIMEOUT_CYCLES=4: start, one sample (1,0,1), then sample_valid low -> timeout=1 exactly 4 cycles after the accept, seen=4'b0100 retained.
- Mid-LEARN with seen=4'b0011: start asserted together with sample_valid (1,1,0) -> sample discarded, seen=0, sample_cnt=0, busy=1; then rst_n low mid-LEARN -> all outputs 0 immediately, no clock needed.
- Full table 4'b1111 learned -> op_code=7; then start from DONE -> done=0, op_code=0, busy=1 next cycle.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared types and constants for the logical-unit identifier.
// Holds the FSM state encoding, the op_code values and the canonical truth tables.
// The truth-table bit index is {a,b}; bit 3 is a=1,b=1.
package lu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEARN = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } lu_state_t;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_NAND  = 3'd4;
  localparam logic [2:0] OP_NOR   = 3'd5;
  localparam logic [2:0] OP_XNOR  = 3'd6;
  localparam logic [2:0] OP_OTHER = 3'd7;

  localparam logic [3:0] FUNC_AND  = 4'b1000;
  localparam logic [3:0] FUNC_OR   = 4'b1110;
  localparam logic [3:0] FUNC_XOR  = 4'b0110;
  localparam logic [3:0] FUNC_NAND = 4'b0111;
  localparam logic [3:0] FUNC_NOR  = 4'b0001;
  localparam logic [3:0] FUNC_XNOR = 4'b1001;

endpackage

// File: rtl/lu_func_classify.sv
// Combinational map from a 4-bit truth table to a named op_code.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the output follows the input every cycle.
module lu_func_classify
  import lu_pkg::*;
(
  input  logic [3:0] func,
  output logic [2:0] op_code
);

  // Match the table against the six named two-input functions; anything else is OTHER.
  always_comb begin
    op_code = OP_OTHER;
    case (func)
      FUNC_AND:  op_code = OP_AND;
      FUNC_OR:   op_code = OP_OR;
      FUNC_XOR:  op_code = OP_XOR;
      FUNC_NAND: op_code = OP_NAND;
      FUNC_NOR:  op_code = OP_NOR;
      FUNC_XNOR: op_code = OP_XNOR;
      default:   op_code = OP_OTHER;
    endcase
  end

endmodule

// File: rtl/logicalunit_identifier.sv
// Recovers a two-input logical unit's truth table from observed (a,b,out) samples.
// Latency: table/state update at the accepting edge; done and op_code visible the cycle after the last new entry.
// Backpressure: sample_ready is high only in LEARN; samples offered in any other state are dropped.
module logicalunit_identifier
  import lu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             a,
  input  logic             b,
  input  logic             out_obs,
  output logic             sample_ready,
  output logic [3:0]       func_est,
  output logic [3:0]       seen,
  output logic             busy,
  output logic             done,
  output logic             conflict,
  output logic             timeout,
  output logic [2:0]       op_code,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  lu_state_t        state_q, state_d;
  logic [3:0]       func_q, func_d;
  logic [3:0]       seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             conflict_q, conflict_d;
  logic             timeout_q, timeout_d;
  logic [2:0]       op_q, op_d;

  logic [1:0]       idx;
  logic             accept;
  logic             mismatch;
  logic [3:0]       func_upd;
  logic [3:0]       seen_upd;
  logic [2:0]       op_class;
  logic [CNT_W-1:0] idle_inc;

  assign idx      = {a, b};
  assign accept   = sample_valid && (state_q == ST_LEARN);
  assign mismatch = seen_q[idx] && (func_q[idx] != out_obs);
  assign idle_inc = idle_q + 1'b1;

  // Candidate table after absorbing the current sample; only first sightings write.
  always_comb begin
    func_upd = func_q;
    seen_upd = seen_q;
    if (!seen_q[idx]) begin
      func_upd[idx] = out_obs;
      seen_upd[idx] = 1'b1;
    end
  end

  // Classify the candidate table so op_code can be registered on the completing edge.
  lu_func_classify u_classify (
    .func    (func_upd),
    .op_code (op_class)
  );

  // Next-state logic: start overrides everything, then per-state learning/sticky behaviour.
  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    seen_d     = seen_q;
    cnt_d      = cnt_q;
    idle_d     = idle_q;
    conflict_d = conflict_q;
    timeout_d  = timeout_q;
    op_d       = op_q;

    if (start) begin
      state_d    = ST_LEARN;
      func_d     = '0;
      seen_d     = '0;
      cnt_d      = '0;
      idle_d     = '0;
      conflict_d = 1'b0;
      timeout_d  = 1'b0;
      op_d       = OP_NONE;
    end else if (state_q == ST_LEARN) begin
      if (accept) begin
        cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        idle_d = '0;
        if (mismatch) begin
          // Contradiction: keep the table as it was before this sample.
          state_d    = ST_ERROR;
          conflict_d = 1'b1;
        end else begin
          func_d = func_upd;
          seen_d = seen_upd;
          if (seen_upd == 4'b1111) begin
            state_d = ST_DONE;
            op_d    = op_class;
          end
        end
      end else begin
        idle_d = idle_inc;
        if (idle_inc == TIMEOUT_LIM) begin
          state_d   = ST_ERROR;
          timeout_d = 1'b1;
        end
      end
    end
  end

  // State and result registers; reset clears everything, including partial learning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      func_q     <= '0;
      seen_q     <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
      op_q       <= OP_NONE;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      seen_q     <= seen_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      conflict_q <= conflict_d;
      timeout_q  <= timeout_d;
      op_q       <= op_d;
    end
  end

  assign sample_ready = (state_q == ST_LEARN);
  assign busy         = (state_q == ST_LEARN);
  assign done         = (state_q == ST_DONE);
  assign conflict     = conflict_q;
  assign timeout      = timeout_q;
  assign func_est     = func_q;
  assign seen         = seen_q;
  assign op_code      = op_q;
  assign sample_cnt   = cnt_q;

endmodule

// File: tb/tb_logicalunit_identifier.sv
// Directed bench for logicalunit_identifier, built with a short idle timeout.
// Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
// Each scenario task carries its own hand-computed expectations.
module tb_logicalunit_identifier;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sample_valid = 1'b0;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             out_obs = 1'b0;
  logic             sample_ready;
  logic [3:0]       func_est;
  logic [3:0]       seen;
  logic             busy;
  logic             done;
  logic             conflict;
  logic             timeout;
  logic [2:0]       op_code;
  logic [CNT_W-1:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  logicalunit_identifier #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sample_valid (sample_valid),
    .a            (a),
    .b            (b),
    .out_obs      (out_obs),
    .sample_ready (sample_ready),
    .func_est     (func_est),
    .seen         (seen),
    .busy         (busy),
    .done         (done),
    .conflict     (conflict),
    .timeout      (timeout),
    .op_code      (op_code),
    .sample_cnt   (sample_cnt)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then wait until just after the rising edge that consumes them.
  task automatic step(input logic v, input logic st, input logic aa, input logic bb, input logic oo);
    @(negedge clk);
    sample_valid = v;
    start        = st;
    a            = aa;
    b            = bb;
    out_obs      = oo;
    @(posedge clk);
    #1;
  endtask

  task automatic go_quiet();
    @(negedge clk);
    sample_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({sample_ready, func_est, seen, busy, done, conflict, timeout, op_code, sample_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b func=%b seen=%b busy=%b done=%b conf=%b to=%b op=%0d cnt=%0d, want all 0",
               sample_ready, func_est, seen, busy, done, conflict, timeout, op_code, sample_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, conflict, timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_flags: got busy/done/conf/to=%b, want 0000", {busy, done, conflict, timeout});
    end
  endtask

  task automatic test_learn_or();
    step(0, 1, 0, 0, 0);
    checks++;
    if (busy !== 1'b1 || sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL or_enter_learn: got busy=%b ready=%b, want 1 1", busy, sample_ready);
    end
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 1, 0, 1);
    checks++;
    if (done !== 1'b0 || seen !== 4'b0111) begin
      errors++;
      $display("FAIL or_partial: got done=%b seen=%b, want 0 0111", done, seen);
    end
    step(1, 0, 1, 1, 1);
    go_quiet();
    checks++;
    if (func_est !== 4'b1110 || seen !== 4'b1111) begin
      errors++;
      $display("FAIL or_table: got func=%b seen=%b, want 1110 1111", func_est, seen);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || op_code !== 3'd2 || sample_cnt !== 8'd4) begin
      errors++;
      $display("FAIL or_done: got done=%b busy=%b op=%0d cnt=%0d, want 1 0 2 4", done, busy, op_code, sample_cnt);
    end
  endtask

  task automatic test_repeat_and();
    step(0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    go_quiet();
    checks++;
    if (func_est !== 4'b1000 || op_code !== 3'd1 || sample_cnt !== 8'd5 || done !== 1'b1) begin
      errors++;
      $display("FAIL and_repeat: got func=%b op=%0d cnt=%0d done=%b, want 1000 1 5 1", func_est, op_code, sample_cnt, done);
    end
    // DONE is sticky: a further sample must not disturb anything.
    step(1, 0, 0, 0, 1);
    go_quiet();
    checks++;
    if (done !== 1'b1 || func_est !== 4'b1000 || sample_cnt !== 8'd5 || sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL and_sticky: got done=%b func=%b cnt=%0d ready=%b, want 1 1000 5 0", done, func_est, sample_cnt, sample_ready);
    end
  endtask

  task automatic test_conflict();
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0);
    go_quiet();
    checks++;
    if (conflict !== 1'b1 || timeout !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL conflict_flags: got conf=%b to=%b done=%b busy=%b ready=%b, want 1 0 0 0 0",
               conflict, timeout, done, busy, sample_ready);
    end
    checks++;
    if (func_est !== 4'b0010 || seen !== 4'b0010) begin
      errors++;
      $display("FAIL conflict_frozen: got func=%b seen=%b, want 0010 0010", func_est, seen);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (conflict !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL conflict_sticky: got conf=%b to=%b, want 1 0", conflict, timeout);
    end
  endtask

  task automatic test_timeout();
    step(0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1);
    go_quiet();
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (timeout !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL timeout_early: cycle %0d got to=%b busy=%b, want 0 1", i, timeout, busy);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (timeout !== 1'b1 || conflict !== 1'b0 || busy !== 1'b0 || seen !== 4'b0100 || func_est !== 4'b0100) begin
      errors++;
      $display("FAIL timeout_hit: got to=%b conf=%b busy=%b seen=%b func=%b, want 1 0 0 0100 0100",
               timeout, conflict, busy, seen, func_est);
    end
  endtask

  task automatic test_start_vs_accept_and_reset();
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    checks++;
    if (seen !== 4'b0011 || sample_cnt !== 8'd2) begin
      errors++;
      $display("FAIL pre_restart: got seen=%b cnt=%0d, want 0011 2", seen, sample_cnt);
    end
    step(1, 1, 1, 1, 0);
    checks++;
    if (seen !== 4'b0000 || sample_cnt !== 8'd0 || func_est !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_wins: got seen=%b cnt=%0d func=%b busy=%b, want 0000 0 0000 1", seen, sample_cnt, func_est, busy);
    end
    step(1, 0, 0, 0, 1);
    go_quiet();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sample_ready, func_est, seen, busy, done, conflict, timeout, op_code, sample_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: got ready=%b func=%b seen=%b busy=%b cnt=%0d, want all 0",
               sample_ready, func_est, seen, busy, sample_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_const_and_restart();
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 1, 1);
    go_quiet();
    checks++;
    if (done !== 1'b1 || op_code !== 3'd7 || func_est !== 4'b1111) begin
      errors++;
      $display("FAIL const_one: got done=%b op=%0d func=%b, want 1 7 1111", done, op_code, func_est);
    end
    step(0, 1, 0, 0, 0);
    go_quiet();
    checks++;
    if (done !== 1'b0 || op_code !== 3'd0 || busy !== 1'b1 || seen !== 4'b0000) begin
      errors++;
      $display("FAIL restart_from_done: got done=%b op=%0d busy=%b seen=%b, want 0 0 1 0000", done, op_code, busy, seen);
    end
  endtask

  // Learn each canonical table and compare the resulting op_code with its expected value.
  task automatic test_classify();
    logic [3:0] tbl [7] = '{4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0000, 4'b1000, 4'b1110};
    logic [2:0] exp [7] = '{3'd3,    3'd4,    3'd5,    3'd6,    3'd7,    3'd1,    3'd2};
    for (int t = 0; t < 7; t++) begin
      logic [3:0] f;
      f = tbl[t];
      step(0, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
        logic [1:0] ix;
        ix = 2'(k);
        step(1, 0, ix[1], ix[0], f[k]);
      end
      go_quiet();
      checks++;
      if (done !== 1'b1 || op_code !== exp[t] || func_est !== f) begin
        errors++;
        $display("FAIL classify_%b: got done=%b op=%0d func=%b, want 1 %0d %b", f, done, op_code, func_est, exp[t], f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_learn_or();
    test_repeat_and();
    test_conflict();
    test_timeout();
    test_start_vs_accept_and_reset();
    test_const_and_restart();
    test_classify();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
